// File: rtl/b03_req_pkg.sv
`default_nettype none
// ============================================================================
// Module      : b03_req_pkg
// Description : Shared types and sizing helpers for the b03 requester agent.
// Revision    : 1.0 - initial release
// ============================================================================
package b03_req_pkg;

  localparam int NUM_CLIENTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } client_state_e;

  // Bits needed for a counter that must reach max_val (never below 1).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/b03_req_client.sv
`default_nettype none
// ============================================================================
// Module      : b03_req_client
// Description : One requester client: job counter, request/hold/release FSM,
//               hold and wait counters, per-client error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module b03_req_client
  import b03_req_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic job_i,          // one new job this cycle
  input  logic grant_bit_i,    // this client's bit of the grant vector
  input  logic grant_legal_i,  // grant vector is zero or one-hot
  output logic request_o,
  output logic done_o,
  output logic active_nxt_o,   // client will be non-idle or have jobs after this edge
  output logic ovf_o,          // job dropped at saturated counter
  output logic spur_o,         // granted while idle
  output logic tmo_o           // wait counter reaches TIMEOUT this edge
);

  localparam int                HOLD_W    = cnt_width(HOLD_CYCLES - 1);
  localparam int                WAIT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

  client_state_e     state_q, state_d;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              request_q;
  logic              done_q;
  logic              w_complete;

  // Next-state, counter updates and error strobes for this client.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    hold_d     = hold_q;
    wait_d     = wait_q;
    w_complete = 1'b0;
    ovf_o      = 1'b0;
    tmo_o      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((pend_q != '0) || job_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant_bit_i && grant_legal_i) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        // A malformed grant vector freezes the hold entirely.
        if (grant_legal_i) begin
          if (!grant_bit_i) begin
            state_d = ST_REQ;            // preempted, job stays queued
          end else if (hold_q == '0) begin
            state_d    = ST_RELEASE;
            w_complete = 1'b1;
          end else begin
            hold_d = hold_q - HOLD_W'(1);
          end
        end
      end
      ST_RELEASE: begin
        if (grant_legal_i && !grant_bit_i) begin
          state_d = ((pend_q != '0) || job_i) ? ST_REQ : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Wait counter only runs while the client stays in REQ.
    if ((state_q == ST_REQ) && (state_d == ST_REQ)) begin
      if (wait_q != WAIT_MAX) begin
        wait_d = wait_q + WAIT_W'(1);
        if ((TIMEOUT != 0) && (wait_d == WAIT_MAX)) tmo_o = 1'b1;
      end
    end else begin
      wait_d = '0;
    end

    // Simultaneous arrival and completion cancel out.
    if (job_i && !w_complete) begin
      if (pend_q == PEND_MAX) ovf_o = 1'b1;
      else                    pend_d = pend_q + CNT_W'(1);
    end else if (w_complete && !job_i) begin
      pend_d = pend_q - CNT_W'(1);
    end
  end

  assign spur_o       = grant_bit_i && (state_q == ST_IDLE);
  assign active_nxt_o = (state_d != ST_IDLE) || (pend_d != '0);
  assign request_o    = request_q;
  assign done_o       = done_q;

  // Client state, counters and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pend_q    <= '0;
      hold_q    <= '0;
      wait_q    <= '0;
      request_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      hold_q    <= hold_d;
      wait_q    <= wait_d;
      request_q <= (state_d == ST_REQ) || (state_d == ST_HOLD);
      done_q    <= w_complete;
    end
  end

endmodule
`default_nettype wire

// File: rtl/b03_requester.sv
`default_nettype none
// ============================================================================
// Module      : b03_requester
// Description : Four-client requester agent for the b03 arbiter. Turns job
//               pulses into requests, holds granted resource, reports errors.
// Revision    : 1.0 - initial release
// ============================================================================
module b03_requester
  import b03_req_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3,
  parameter int TIMEOUT     = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] job_valid,
  input  logic [3:0] grant_i,
  input  logic       clr_err,
  output logic       request1,
  output logic       request2,
  output logic       request3,
  output logic       request4,
  output logic [3:0] done,
  output logic       busy,
  output logic       err_overflow,
  output logic       err_spurious,
  output logic       err_timeout
);

  logic                   w_grant_legal;
  logic [NUM_CLIENTS-1:0] w_request;
  logic [NUM_CLIENTS-1:0] w_done;
  logic [NUM_CLIENTS-1:0] w_active_nxt;
  logic [NUM_CLIENTS-1:0] w_ovf;
  logic [NUM_CLIENTS-1:0] w_spur;
  logic [NUM_CLIENTS-1:0] w_tmo;

  logic busy_q;
  logic ovf_q;
  logic spur_q;
  logic tmo_q;

  assign w_grant_legal = $onehot0(grant_i);

  for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_client
    b03_req_client #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W),
      .TIMEOUT     (TIMEOUT)
    ) u_client (
      .clk_i         (clock),
      .rst_i         (reset),
      .job_i         (job_valid[gi]),
      .grant_bit_i   (grant_i[gi]),
      .grant_legal_i (w_grant_legal),
      .request_o     (w_request[gi]),
      .done_o        (w_done[gi]),
      .active_nxt_o  (w_active_nxt[gi]),
      .ovf_o         (w_ovf[gi]),
      .spur_o        (w_spur[gi]),
      .tmo_o         (w_tmo[gi])
    );
  end

  // Busy and sticky error flags; a new error beats a same-cycle clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      spur_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      busy_q <= |w_active_nxt;
      ovf_q  <= (|w_ovf) | (ovf_q & ~clr_err);
      spur_q <= (|w_spur) | ~w_grant_legal | (spur_q & ~clr_err);
      tmo_q  <= (|w_tmo) | (tmo_q & ~clr_err);
    end
  end

  assign request1     = w_request[0];
  assign request2     = w_request[1];
  assign request3     = w_request[2];
  assign request4     = w_request[3];
  assign done         = w_done;
  assign busy         = busy_q;
  assign err_overflow = ovf_q;
  assign err_spurious = spur_q;
  assign err_timeout  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_b03_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_b03_requester
// Description : Directed and random checks of b03_requester against a
//               job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_b03_requester;

  localparam int HOLD = 4;
  localparam int CW   = 3;
  localparam int TMO  = 64;
  localparam int PMAX = (1 << CW) - 1;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] job_valid;
  logic [3:0] grant_i;
  logic       clr_err;
  logic       request1, request2, request3, request4;
  logic [3:0] done;
  logic       busy, err_overflow, err_spurious, err_timeout;

  b03_requester #(
    .HOLD_CYCLES (HOLD),
    .CNT_W       (CW),
    .TIMEOUT     (TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .job_valid    (job_valid),
    .grant_i      (grant_i),
    .clr_err      (clr_err),
    .request1     (request1),
    .request2     (request2),
    .request3     (request3),
    .request4     (request4),
    .done         (done),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_spurious (err_spurious),
    .err_timeout  (err_timeout)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: each client is waiting, owning, cooling down, or idle.
  int   m_pend [4];
  int   m_held [4];
  int   m_wait [4];
  bit   m_want [4];
  bit   m_own  [4];
  bit   m_cool [4];
  logic [3:0] m_done;
  bit   m_ovf, m_spur, m_tmo;

  logic [3:0] g, jv;
  int         n_done, r, start;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = 0; m_held[i] = 0; m_wait[i] = 0;
      m_want[i] = 0; m_own[i] = 0;  m_cool[i] = 0;
    end
    m_done = '0;
    m_ovf = 0; m_spur = 0; m_tmo = 0;
  endtask

  task automatic model_edge(input logic [3:0] jin, input logic [3:0] gin, input logic clr);
    bit legal, s_ovf, s_spur, s_tmo, comp;
    legal  = ($countones(gin) <= 1);
    s_ovf  = 0;
    s_spur = !legal;
    s_tmo  = 0;
    for (int i = 0; i < 4; i++) begin
      comp = 0;
      if (gin[i] && !m_want[i] && !m_own[i] && !m_cool[i]) s_spur = 1;
      if (m_own[i]) begin
        if (legal) begin
          if (!gin[i]) begin
            m_own[i] = 0; m_want[i] = 1; m_wait[i] = 0;
          end else if (m_held[i] + 1 == HOLD) begin
            m_own[i] = 0; m_cool[i] = 1; comp = 1;
          end else begin
            m_held[i]++;
          end
        end
      end else if (m_want[i]) begin
        if (legal && gin[i]) begin
          m_want[i] = 0; m_own[i] = 1; m_held[i] = 0;
        end else if (m_wait[i] < TMO) begin
          m_wait[i]++;
          if (m_wait[i] == TMO) s_tmo = 1;
        end
      end else if (m_cool[i]) begin
        if (legal && !gin[i]) begin
          m_cool[i] = 0;
          if (m_pend[i] > 0 || jin[i]) begin m_want[i] = 1; m_wait[i] = 0; end
        end
      end else if (m_pend[i] > 0 || jin[i]) begin
        m_want[i] = 1; m_wait[i] = 0;
      end
      if (jin[i] && !comp) begin
        if (m_pend[i] == PMAX) s_ovf = 1;
        else                   m_pend[i]++;
      end else if (comp && !jin[i]) begin
        m_pend[i]--;
      end
      m_done[i] = comp;
    end
    m_ovf  = s_ovf  | (m_ovf  & !clr);
    m_spur = s_spur | (m_spur & !clr);
    m_tmo  = s_tmo  | (m_tmo  & !clr);
  endtask

  function automatic logic [3:0] exp_req();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_want[i] | m_own[i];
    return v;
  endfunction

  function automatic logic exp_busy();
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++)
      if (m_want[i] || m_own[i] || m_cool[i] || m_pend[i] > 0) b = 1'b1;
    return b;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check($sformatf("%s.req", tag), 8'({request4, request3, request2, request1}), 8'(exp_req()));
    check($sformatf("%s.done", tag), 8'(done), 8'(m_done));
    check($sformatf("%s.busy", tag), 8'(busy), 8'(exp_busy()));
    check($sformatf("%s.flags", tag), 8'({err_overflow, err_spurious, err_timeout}),
          8'({m_ovf, m_spur, m_tmo}));
  endtask

  // Apply one cycle of inputs, advance model and DUT, compare everything.
  task automatic step(input string tag, input logic [3:0] jin, input logic [3:0] gin, input logic clr);
    job_valid = jin;
    grant_i   = gin;
    clr_err   = clr;
    model_edge(jin, gin, clr);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1; job_valid = '0; grant_i = '0; clr_err = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();

    // Single job on client 0, full hold, release
    step("c0_job", 4'b0001, 4'b0000, 1'b0);
    check("c0_req1_rise", 8'(request1), 8'd1);
    step("c0_g0", 4'b0000, 4'b0001, 1'b0);
    for (int k = 1; k < HOLD; k++) begin
      step("c0_hold", 4'b0000, 4'b0001, 1'b0);
      check("c0_no_early_done", 8'(done[0]), 8'd0);
    end
    step("c0_end", 4'b0000, 4'b0001, 1'b0);
    check("c0_done_pulse", 8'(done[0]), 8'd1);
    check("c0_req1_fall", 8'(request1), 8'd0);
    step("c0_rel", 4'b0000, 4'b0000, 1'b0);
    check("c0_idle_busy", 8'(busy), 8'd0);

    // Three jobs on client 2 served by a grant that follows the request
    step("c2_j1", 4'b0100, 4'b0000, 1'b0);
    step("c2_gap", 4'b0000, 4'b0000, 1'b0);
    step("c2_j2", 4'b0100, 4'b0000, 1'b0);
    step("c2_gap", 4'b0000, 4'b0000, 1'b0);
    step("c2_j3", 4'b0100, 4'b0000, 1'b0);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      g = (m_want[2] || m_own[2]) ? 4'b0100 : 4'b0000;
      step("c2_serve", 4'b0000, g, 1'b0);
      if (done[2]) n_done++;
    end
    check("c2_done_count", 8'(n_done), 8'd3);
    check("c2_final_busy", 8'(busy), 8'd0);

    // Counter saturation on client 1
    do_reset();
    for (int k = 0; k < PMAX; k++) step("ovf_fill", 4'b0010, 4'b0000, 1'b0);
    check("ovf_not_yet", 8'(err_overflow), 8'd0);
    step("ovf_8th", 4'b0010, 4'b0000, 1'b0);
    check("ovf_set", 8'(err_overflow), 8'd1);
    step("ovf_clr", 4'b0000, 4'b0000, 1'b1);
    check("ovf_cleared", 8'(err_overflow), 8'd0);

    // Timeout with all four waiting
    do_reset();
    step("tmo_jobs", 4'b1111, 4'b0000, 1'b0);
    for (int k = 1; k < TMO; k++) step("tmo_wait", 4'b0000, 4'b0000, 1'b0);
    check("tmo_not_yet", 8'(err_timeout), 8'd0);
    step("tmo_hit", 4'b0000, 4'b0000, 1'b0);
    check("tmo_set", 8'(err_timeout), 8'd1);
    step("tmo_after", 4'b0000, 4'b0000, 1'b0);
    check("tmo_reqs_high", 8'({request4, request3, request2, request1}), 8'h0f);

    // Spurious grants
    do_reset();
    step("sp_jobs", 4'b0110, 4'b0000, 1'b0);
    step("sp_multi", 4'b0000, 4'b0110, 1'b0);
    check("sp_multi_flag", 8'(err_spurious), 8'd1);
    check("sp_multi_reqs", 8'({request4, request3, request2, request1}), 8'h06);
    step("sp_clr", 4'b0000, 4'b0000, 1'b1);
    check("sp_cleared", 8'(err_spurious), 8'd0);
    step("sp_idle", 4'b0000, 4'b1000, 1'b0);
    check("sp_idle_flag", 8'(err_spurious), 8'd1);

    // Preemption during hold, then asynchronous reset during hold
    do_reset();
    step("pre_job", 4'b0001, 4'b0000, 1'b0);
    step("pre_g0", 4'b0000, 4'b0001, 1'b0);
    step("pre_g1", 4'b0000, 4'b0001, 1'b0);
    step("pre_drop", 4'b0000, 4'b0000, 1'b0);
    check("pre_req_kept", 8'(request1), 8'd1);
    check("pre_no_done", 8'(done), 8'd0);
    step("pre_regrant", 4'b0000, 4'b0001, 1'b0);
    step("pre_hold", 4'b0000, 4'b0001, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_req1", 8'(request1), 8'd0);
    check_all("async_rst");
    @(posedge clock);
    #1;
    reset = 1'b0;
    step("post_rst", 4'b0000, 4'b0000, 1'b0);
    check("post_rst_idle", 8'({busy, request1}), 8'd0);

    // Random traffic against a well-behaved arbiter with occasional junk
    do_reset();
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) jv[i] = ($urandom_range(0, 4) == 0);
      r = $urandom_range(0, 99);
      g = 4'b0000;
      if (r < 3) begin
        g = 4'($urandom);
      end else begin
        for (int i = 0; i < 4; i++)
          if (m_own[i] && $urandom_range(0, 9) != 0) g = 4'(1 << i);
        if (g == 4'b0000 && r >= 20) begin
          start = $urandom_range(0, 3);
          for (int j = 0; j < 4; j++)
            if (g == 4'b0000 && m_want[(start + j) % 4]) g = 4'(1 << ((start + j) % 4));
        end
      end
      step("rand", jv, g, ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
